// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: widths, opcodes, the NOP encoding and the
// ID/EX pipeline register layout used by the decode stage.
package cpu_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned NumRegs      = 2 ** RegAddrWidth;

  // Primary opcode field values (instr[31:26]).
  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [DataWidth-1:0] NopInstr = 32'h0000_0000;

  // ID/EX latch contents; an all-zero value is a bubble.
  typedef struct packed {
    logic [DataWidth-1:0]    pc_next;
    logic [DataWidth-1:0]    pc_branch;
    logic [DataWidth-1:0]    read_data1;
    logic [DataWidth-1:0]    read_data2;
    logic [DataWidth-1:0]    imm_ext;
    logic [RegAddrWidth-1:0] rs;
    logic [RegAddrWidth-1:0] rt;
    logic [RegAddrWidth-1:0] rd;
    logic [5:0]              opcode;
    logic [5:0]              funct;
    logic                    valid;
  } idex_t;

  // Logical immediates are zero-extended, everything else sign-extended.
  function automatic logic [DataWidth-1:0] extend_imm(input logic [5:0]  opcode,
                                                      input logic [15:0] imm);
    if (opcode == OpAndi || opcode == OpOri || opcode == OpXori) begin
      return {16'h0000, imm};
    end
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two read ports, one write port, r0 hard-wired to zero,
// same-cycle write-to-read bypass. Optional debug read port under
// DEBUG_REGFILE_EN.
module register_file
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [RegAddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [RegAddrWidth-1:0] raddr1_i,
  input  logic [RegAddrWidth-1:0] raddr2_i,
  output logic [DataWidth-1:0]    rdata1_o,
  output logic [DataWidth-1:0]    rdata2_o
`ifdef DEBUG_REGFILE_EN
  ,
  input  logic [RegAddrWidth-1:0] dbg_addr_i,
  output logic [DataWidth-1:0]    dbg_data_o
`endif
);

  logic [DataWidth-1:0] regs_q [NumRegs];

  // A pending write to the addressed register is forwarded; r0 always reads 0.
  function automatic logic [DataWidth-1:0] read_port(input logic [RegAddrWidth-1:0] addr,
                                                     input logic [DataWidth-1:0]    stored,
                                                     input logic                    we,
                                                     input logic [RegAddrWidth-1:0] waddr,
                                                     input logic [DataWidth-1:0]    wdata);
    if (addr == '0) begin
      return '0;
    end
    if (we && (waddr == addr)) begin
      return wdata;
    end
    return stored;
  endfunction

  // Register storage: reset clears every entry, writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read ports with bypass.
  always_comb begin
    rdata1_o = read_port(raddr1_i, regs_q[raddr1_i], we_i, waddr_i, wdata_i);
    rdata2_o = read_port(raddr2_i, regs_q[raddr2_i], we_i, waddr_i, wdata_i);
  end

`ifdef DEBUG_REGFILE_EN
  // Debug read port sees the same bypassed view as the pipeline.
  always_comb begin
    dbg_data_o = read_port(dbg_addr_i, regs_q[dbg_addr_i], we_i, waddr_i, wdata_i);
  end
`endif

endmodule

// File: rtl/instruction_decode.sv
// Instruction decode stage: IF/ID latch, register file read, immediate
// extension, branch target and a registered ID/EX output latch.
// Optional feature macro: DEBUG_REGFILE_EN adds a combinational debug read
// port (i_dbg_reg_addr / o_dbg_reg_data) into the register file.
module instruction_decode
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    i_IFIDWrite,
  input  logic                    i_flush,
  input  logic [DataWidth-1:0]    i_PCNext,
  input  logic [DataWidth-1:0]    i_instruction,
  input  logic                    i_RegWrite,
  input  logic [RegAddrWidth-1:0] i_write_reg,
  input  logic [DataWidth-1:0]    i_write_data,
  output logic [DataWidth-1:0]    o_PCNext,
  output logic [DataWidth-1:0]    o_PCBranch,
  output logic [DataWidth-1:0]    o_read_data1,
  output logic [DataWidth-1:0]    o_read_data2,
  output logic [DataWidth-1:0]    o_imm_ext,
  output logic [RegAddrWidth-1:0] o_rs,
  output logic [RegAddrWidth-1:0] o_rt,
  output logic [RegAddrWidth-1:0] o_rd,
  output logic [5:0]              o_opcode,
  output logic [5:0]              o_funct,
  output logic                    o_valid
`ifdef DEBUG_REGFILE_EN
  ,
  input  logic [RegAddrWidth-1:0] i_dbg_reg_addr,
  output logic [DataWidth-1:0]    o_dbg_reg_data
`endif
);

  logic [DataWidth-1:0] ifid_pc_q, ifid_pc_d;
  logic [DataWidth-1:0] ifid_instr_q, ifid_instr_d;
  logic                 ifid_valid_q, ifid_valid_d;
  idex_t                idex_q, idex_d;

  logic                 rf_we;
  logic [DataWidth-1:0] rf_rdata1;
  logic [DataWidth-1:0] rf_rdata2;

  // Shamt is not forwarded by this stage.
  logic unused_shamt;
  assign unused_shamt = ^ifid_instr_q[10:6];

  // Writeback is suppressed while the pipeline is disabled.
  assign rf_we = i_RegWrite & enable;

  register_file u_register_file (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (i_write_reg),
    .wdata_i    (i_write_data),
    .raddr1_i   (ifid_instr_q[25:21]),
    .raddr2_i   (ifid_instr_q[20:16]),
    .rdata1_o   (rf_rdata1),
    .rdata2_o   (rf_rdata2)
`ifdef DEBUG_REGFILE_EN
    ,
    .dbg_addr_i (i_dbg_reg_addr),
    .dbg_data_o (o_dbg_reg_data)
`endif
  );

  // IF/ID next state: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (enable) begin
      if (i_flush) begin
        ifid_pc_d    = '0;
        ifid_instr_d = NopInstr;
        ifid_valid_d = 1'b0;
      end else if (i_IFIDWrite) begin
        ifid_pc_d    = i_PCNext;
        ifid_instr_d = i_instruction;
        ifid_valid_d = 1'b1;
      end
    end
  end

  // IF/ID latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= NopInstr;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // ID/EX next state: decode the IF/ID word, or insert a bubble on a stall or
  // when IF/ID holds nothing valid (e.g. after a flush).
  always_comb begin
    idex_d = idex_q;
    if (enable) begin
      if (!i_IFIDWrite || !ifid_valid_q) begin
        idex_d = '0;
      end else begin
        idex_d.pc_next    = ifid_pc_q;
        idex_d.pc_branch  = ifid_pc_q + {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
        idex_d.read_data1 = rf_rdata1;
        idex_d.read_data2 = rf_rdata2;
        idex_d.imm_ext    = extend_imm(ifid_instr_q[31:26], ifid_instr_q[15:0]);
        idex_d.rs         = ifid_instr_q[25:21];
        idex_d.rt         = ifid_instr_q[20:16];
        idex_d.rd         = ifid_instr_q[15:11];
        idex_d.opcode     = ifid_instr_q[31:26];
        idex_d.funct      = ifid_instr_q[5:0];
        idex_d.valid      = 1'b1;
      end
    end
  end

  // ID/EX latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign o_PCNext     = idex_q.pc_next;
  assign o_PCBranch   = idex_q.pc_branch;
  assign o_read_data1 = idex_q.read_data1;
  assign o_read_data2 = idex_q.read_data2;
  assign o_imm_ext    = idex_q.imm_ext;
  assign o_rs         = idex_q.rs;
  assign o_rt         = idex_q.rt;
  assign o_rd         = idex_q.rd;
  assign o_opcode     = idex_q.opcode;
  assign o_funct      = idex_q.funct;
  assign o_valid      = idex_q.valid;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst, enable, i_IFIDWrite, i_flush, i_RegWrite;
  logic [31:0] i_PCNext, i_instruction, i_write_data;
  logic [4:0]  i_write_reg;
  logic [31:0] o_PCNext, o_PCBranch, o_read_data1, o_read_data2, o_imm_ext;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [5:0]  o_opcode, o_funct;
  logic        o_valid;
`ifdef DEBUG_REGFILE_EN
  logic [4:0]  i_dbg_reg_addr = 5'd0;
  logic [31:0] o_dbg_reg_data;
`endif

  int tests = 0;
  int fails = 0;

  // Model state: architectural registers, the word waiting in decode, and
  // the output bundle expected after the most recent edge.
  logic [31:0]  m_regs [32];
  logic [31:0]  m_pc, m_instr;
  bit           m_valid;
  logic [187:0] m_out;
  logic [187:0] obs;

  assign obs = {o_PCNext, o_PCBranch, o_read_data1, o_read_data2, o_imm_ext,
                o_rs, o_rt, o_rd, o_opcode, o_funct, o_valid};

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .i_IFIDWrite   (i_IFIDWrite),
    .i_flush       (i_flush),
    .i_PCNext      (i_PCNext),
    .i_instruction (i_instruction),
    .i_RegWrite    (i_RegWrite),
    .i_write_reg   (i_write_reg),
    .i_write_data  (i_write_data),
    .o_PCNext      (o_PCNext),
    .o_PCBranch    (o_PCBranch),
    .o_read_data1  (o_read_data1),
    .o_read_data2  (o_read_data2),
    .o_imm_ext     (o_imm_ext),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_opcode      (o_opcode),
    .o_funct       (o_funct),
    .o_valid       (o_valid)
`ifdef DEBUG_REGFILE_EN
    ,
    .i_dbg_reg_addr (i_dbg_reg_addr),
    .o_dbg_reg_data (o_dbg_reg_data)
`endif
  );

  task automatic check(input string tag, input logic [187:0] observed,
                       input logic [187:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Register value seen by a reader this cycle, honouring a concurrent write.
  function automatic logic [31:0] model_read(input logic [4:0] a, input bit wr_en,
                                             input logic [4:0] wr, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wr_en && a == wr) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [187:0] model_decode(input logic [31:0] pc, input logic [31:0] ins,
                                                input logic [31:0] r1, input logic [31:0] r2);
    logic [5:0]  op;
    logic [31:0] sext, imm;
    op   = ins[31:26];
    sext = {{16{ins[15]}}, ins[15:0]};
    imm  = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'd0, ins[15:0]} : sext;
    return {pc, pc + sext, r1, r2, imm, ins[25:21], ins[20:16], ins[15:11], op, ins[5:0],
            1'b1};
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input string tag, input bit r, input bit en, input bit ifw,
                      input bit fl, input logic [31:0] pc, input logic [31:0] ins,
                      input bit rw, input logic [4:0] wr, input logic [31:0] wd);
    bit wr_en;
    @(negedge clk);
    rst = r; enable = en; i_IFIDWrite = ifw; i_flush = fl;
    i_PCNext = pc; i_instruction = ins;
    i_RegWrite = rw; i_write_reg = wr; i_write_data = wd;
    wr_en = rw && en;
    if (r) begin
      m_out = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
    end else if (en) begin
      if (!ifw || !m_valid) m_out = '0;
      else m_out = model_decode(m_pc, m_instr,
                                model_read(m_instr[25:21], wr_en, wr, wd),
                                model_read(m_instr[20:16], wr_en, wr, wd));
      if (wr_en && wr != 5'd0) m_regs[wr] = wd;
      if (fl) begin
        m_instr = 32'd0; m_valid = 1'b0;
      end else if (ifw) begin
        m_pc = pc; m_instr = ins; m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check(tag, obs, m_out);
  endtask

  task automatic run(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    step(tag, 0, 1, 1, 0, pc, ins, 0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [5:0]  ops [10];
    logic [31:0] rnd, ins;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
    rst = 1; enable = 1; i_IFIDWrite = 1; i_flush = 0; i_RegWrite = 0;
    i_write_reg = 0; i_write_data = 0; i_PCNext = 0; i_instruction = 0;

    // Reset for two cycles, even with flush/writeback active.
    step("reset1", 1, 1, 1, 1, 32'h11, 32'hFFFF_FFFF, 1, 5'd5, 32'h55);
    step("reset2", 1, 0, 0, 0, 32'h12, 32'h1234_5678, 1, 5'd5, 32'h55);
    check("reset_valid", o_valid, 1'b0);
    check("reset_all", obs, 188'd0);
    run("r5_present", 32'd1, 32'h00A0_0000);
    check("bubble_after_reset", o_valid, 1'b0);
    run("r5_out", 32'd2, 32'h0000_0000);
    check("r5_reads_zero", o_read_data1, 32'd0);
    check("r5_rs", o_rs, 5'd5);

    // Write r3 then decode add r2,r3,r1.
    step("wb_r3", 0, 1, 1, 0, 32'd3, 32'd0, 1, 5'd3, 32'h1234);
    run("add_in", 32'd4, 32'h0061_1020);
    run("add_out", 32'd5, 32'd0);
    check("add_rd1", o_read_data1, 32'h1234);
    check("add_fields", {o_rs, o_rt, o_rd, o_valid}, {5'd3, 5'd1, 5'd2, 1'b1});

    // Bypass: write r4 while decode reads it.
    run("byp_in", 32'd6, 32'h0080_0000);
    step("byp_wb", 0, 1, 1, 0, 32'd7, 32'd0, 1, 5'd4, 32'hABCD);
    check("bypass_rd1", o_read_data1, 32'hABCD);

    // beq at PC 5 with imm -2, then ori with imm 0x8000.
    run("beq_in", 32'd5, 32'h1000_FFFE);
    run("ori_in", 32'd6, 32'h3400_8000);
    check("beq_imm", o_imm_ext, 32'hFFFF_FFFE);
    check("beq_target", o_PCBranch, 32'd3);
    run("ori_out", 32'd7, 32'd0);
    check("ori_imm", o_imm_ext, 32'h0000_8000);

    // One-cycle stall, then flush together with stall.
    run("x_in", 32'd20, 32'h00A6_3820);
    step("stall", 0, 1, 0, 0, 32'd21, 32'h00E8_4820, 0, 5'd0, 32'd0);
    check("stall_bubble", o_valid, 1'b0);
    run("y_in", 32'd21, 32'h00E8_4820);
    check("held_x_out", {o_rd, o_valid}, {5'd7, 1'b1});
    step("flush", 0, 1, 0, 1, 32'd22, 32'h0128_5820, 0, 5'd0, 32'd0);
    check("flush_bubble", o_valid, 1'b0);
    run("w_in", 32'd23, 32'h0109_5020);
    check("y_lost", o_valid, 1'b0);
    run("w_out", 32'd24, 32'd0);
    check("w_rd", {o_rd, o_valid}, {5'd10, 1'b1});

    // Disable for three cycles with a writeback to r7 pending.
    step("wb_r7", 0, 1, 1, 0, 32'd29, 32'd0, 1, 5'd7, 32'h77);
    run("r7_in", 32'd30, 32'h00E0_0000);
    for (int i = 0; i < 3; i++)
      step("frozen", 0, 0, 1, 0, 32'd40, 32'hFFFF_FFFF, 1, 5'd7, 32'hDEAD);
    run("r7_out", 32'd31, 32'd0);
    check("r7_unchanged", o_read_data1, 32'h77);
    step("wb_r0", 0, 1, 1, 0, 32'd32, 32'd0, 1, 5'd0, 32'hFFFF);
    check("r0_bypass_zero", o_read_data1, 32'd0);
    run("r0_out", 32'd33, 32'd0);
    check("r0_reads_zero", o_read_data1, 32'd0);

    // Randomized traffic including occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      ins = {ops[$urandom_range(9)], rnd[25:0]};
      step("random", $urandom_range(39) == 0, $urandom_range(99) < 85,
           $urandom_range(99) < 80, $urandom_range(99) < 15, $urandom(), ins,
           $urandom_range(1) == 1, 5'($urandom_range(31)), $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
